// File: rtl/fifo_pin_driver_if.sv
// Stream and tile-pin bundle for fifo_pin_driver: upstream push stream,
// downstream pop stream and the FIFO tile's strobe/flag pins.
interface fifo_pin_driver_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] fifo_din;
    logic       fifo_wr;
    logic       fifo_rd;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;

    modport master (
        input  s_data, s_valid, m_ready, fifo_dout, fifo_empty, fifo_full,
        output s_ready, m_data, m_valid, fifo_din, fifo_wr, fifo_rd
    );

    modport slave (
        output s_data, s_valid, m_ready, fifo_dout, fifo_empty, fifo_full,
        input  s_ready, m_data, m_valid, fifo_din, fifo_wr, fifo_rd
    );
endinterface

// File: rtl/fifo_pin_driver.sv
// Host-side driver for the FIFO tile pins: turns a byte stream into write
// strobes and pops bytes back out through read strobes into an output buffer.
module fifo_pin_driver #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned OUT_DEPTH  = 2
) (
    input logic               clk,
    input logic               rst_n,
    fifo_pin_driver_if.master bus
);
    localparam int unsigned   PTR_W    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned   CNT_W    = PTR_W + 1;
    localparam logic [1:0]    LAT_LAST = 2'(RD_LATENCY - 1);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(OUT_DEPTH);

    typedef enum logic [2:0] {IDLE, WR, RD, CAP, SETTLE} state_t;
    typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

    state_t           state, next_state;
    grant_t           last_grant;
    logic [7:0]       hold_data;
    logic             hold_valid;
    logic             inflight;
    logic [1:0]       wait_cnt;
    logic [7:0]       out_mem [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] out_count;
    logic [CNT_W:0]   occupancy;
    logic             wr_q, rd_q, wr_d, rd_d;
    logic [7:0]       din_q, din_d;
    logic             s_fire, m_fire, cap_last, can_wr, can_rd;

    assign s_fire    = bus.s_valid && !hold_valid;
    assign m_fire    = (out_count != '0) && bus.m_ready;
    assign cap_last  = (state == CAP) && (wait_cnt == LAT_LAST);
    // Reads reserve a buffer slot while in flight so a captured byte always has room.
    assign occupancy = {1'b0, out_count} + {{CNT_W{1'b0}}, inflight};
    assign can_wr    = hold_valid && !bus.fifo_full;
    assign can_rd    = !bus.fifo_empty && (occupancy < DEPTH_V);

    assign bus.s_ready  = !hold_valid;
    assign bus.m_valid  = (out_count != '0);
    assign bus.m_data   = out_mem[rd_ptr];
    assign bus.fifo_wr  = wr_q;
    assign bus.fifo_rd  = rd_q;
    assign bus.fifo_din = din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (can_wr && can_rd)
                    next_state = (last_grant == GRANT_READ) ? WR : RD;
                else if (can_wr)
                    next_state = WR;
                else if (can_rd)
                    next_state = RD;
            end
            WR:      next_state = SETTLE;
            RD:      next_state = CAP;
            CAP:     next_state = cap_last ? IDLE : CAP;
            SETTLE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so the pins are flop outputs
    // that are high exactly while the FSM sits in WR or RD.
    always_comb begin
        wr_d  = (next_state == WR);
        rd_d  = (next_state == RD);
        din_d = (next_state == WR) ? hold_data : din_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            din_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            din_q <= din_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            last_grant <= GRANT_READ;
            inflight   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (s_fire) begin
                hold_data  <= bus.s_data;
                hold_valid <= 1'b1;
            end else if (state == WR) begin
                hold_valid <= 1'b0;
            end
            if (state == WR) last_grant <= GRANT_WRITE;
            if (state == RD) last_grant <= GRANT_READ;
            if (state == RD)    inflight <= 1'b1;
            else if (cap_last)  inflight <= 1'b0;
            wait_cnt <= (state == CAP) ? wait_cnt + 2'd1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_count <= '0;
        end else begin
            if (cap_last) begin
                out_mem[wr_ptr] <= bus.fifo_dout;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (m_fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({cap_last, m_fire})
                2'b10:   out_count <= out_count + CNT_W'(1);
                2'b01:   out_count <= out_count - CNT_W'(1);
                default: out_count <= out_count;
            endcase
        end
    end
endmodule
